// File: rtl/host_uart_pkg.sv
// Shared constants and types for the host-UART response framer.
package host_uart_pkg;

  localparam logic [15:0] ENCRYPT_ENABLE_RSP  = 16'h0001;
  localparam logic [15:0] READ_YAW_RSP        = 16'h0002;
  localparam logic [15:0] INVALID_COMMAND_RSP = 16'h0004;
  localparam logic [15:0] GENERIC_RSP         = 16'h0008;

  localparam logic [7:0] SOF_BYTE       = 8'hA5;
  localparam logic [7:0] STATUS_SUCCESS = 8'h01;
  localparam logic [7:0] STATUS_FAIL    = 8'h00;

  localparam logic [2:0] HDR_LAST_IDX   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_CKSUM,
    ST_FIN
  } framer_state_e;

endpackage

// File: rtl/host_uart_rsp_rules.sv
// Resolves per-response frame length, status byte and legality.
module host_uart_rsp_rules
  import host_uart_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD_BYTES = 32,
  parameter int unsigned LEN_W             = $clog2(MAX_PAYLOAD_BYTES + 1)
) (
  input  logic [15:0]      cmd_select,
  input  logic             suc_or_fail_status,
  input  logic [LEN_W-1:0] payload_len,
  output logic [LEN_W-1:0] len,
  output logic [7:0]       status_byte,
  output logic             legal
);

  always_comb begin
    len         = '0;
    status_byte = suc_or_fail_status ? STATUS_SUCCESS : STATUS_FAIL;
    legal       = 1'b0;
    case (cmd_select)
      ENCRYPT_ENABLE_RSP: legal = 1'b1;
      READ_YAW_RSP: begin
        legal = 1'b1;
        if (suc_or_fail_status) len = LEN_W'(4);
      end
      INVALID_COMMAND_RSP: begin
        legal       = 1'b1;
        status_byte = STATUS_FAIL;
      end
      GENERIC_RSP: begin
        legal = (32'(payload_len) <= MAX_PAYLOAD_BYTES);
        len   = payload_len;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/host_uart_rsp_framer.sv
// Host-UART response framer: SOF, ID, status, LEN, payload, XOR checksum on a valid/ready byte stream.
module host_uart_rsp_framer
  import host_uart_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD_BYTES = 32,
  parameter int unsigned LEN_W             = $clog2(MAX_PAYLOAD_BYTES + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [15:0]                    cmd_select,
  input  logic                           suc_or_fail_status,
  input  logic [8*MAX_PAYLOAD_BYTES-1:0] payload,
  input  logic [LEN_W-1:0]               payload_len,
  output logic [7:0]                     tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           error
);

  localparam int unsigned PIDX_W = (MAX_PAYLOAD_BYTES > 1) ? $clog2(MAX_PAYLOAD_BYTES) : 1;

  framer_state_e     state_r;
  logic [2:0]        hdr_idx_r;
  logic [PIDX_W-1:0] pay_idx_r;
  logic [15:0]       id_r;
  logic [7:0]        status_r;
  logic [LEN_W-1:0]  len_r;
  logic [7:0]        pay_r [MAX_PAYLOAD_BYTES];
  logic [7:0]        cksum_r;
  logic              rej_r;

  logic [LEN_W-1:0]  rule_len;
  logic [7:0]        rule_status;
  logic              rule_legal;
  logic              hs;
  logic              pay_last;

  host_uart_rsp_rules #(
    .MAX_PAYLOAD_BYTES (MAX_PAYLOAD_BYTES),
    .LEN_W             (LEN_W)
  ) u_rules (
    .cmd_select         (cmd_select),
    .suc_or_fail_status (suc_or_fail_status),
    .payload_len        (payload_len),
    .len                (rule_len),
    .status_byte        (rule_status),
    .legal              (rule_legal)
  );

  assign hs       = tx_valid && tx_ready;
  assign pay_last = (LEN_W'(pay_idx_r) + LEN_W'(1)) == len_r;

  // FIN behaves like IDLE for a new start so frames can run back to back.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      hdr_idx_r <= '0;
      pay_idx_r <= '0;
      id_r      <= '0;
      status_r  <= '0;
      len_r     <= '0;
      cksum_r   <= '0;
      rej_r     <= 1'b0;
      for (int unsigned i = 0; i < MAX_PAYLOAD_BYTES; i++) pay_r[i] <= '0;
    end else begin
      rej_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_FIN: begin
          state_r <= ST_IDLE;
          if (start) begin
            if (rule_legal) begin
              state_r   <= ST_HDR;
              id_r      <= cmd_select;
              status_r  <= rule_status;
              len_r     <= rule_len;
              hdr_idx_r <= '0;
              pay_idx_r <= '0;
              cksum_r   <= '0;
              for (int unsigned i = 0; i < MAX_PAYLOAD_BYTES; i++) pay_r[i] <= payload[8*i +: 8];
            end else begin
              rej_r <= 1'b1;
            end
          end
        end
        ST_HDR: begin
          if (hs) begin
            if (hdr_idx_r != '0) cksum_r <= cksum_r ^ tx_data;
            if (hdr_idx_r == HDR_LAST_IDX) begin
              state_r <= (len_r != '0) ? ST_PAYLOAD : ST_CKSUM;
            end else begin
              hdr_idx_r <= hdr_idx_r + 3'd1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (hs) begin
            cksum_r <= cksum_r ^ tx_data;
            if (pay_last) state_r <= ST_CKSUM;
            else          pay_idx_r <= pay_idx_r + PIDX_W'(1);
          end
        end
        ST_CKSUM: begin
          if (hs) state_r <= ST_FIN;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Output byte is a pure function of registered state, so it holds steady through stalls.
  always_comb begin
    tx_data  = '0;
    tx_valid = 1'b0;
    case (state_r)
      ST_HDR: begin
        tx_valid = 1'b1;
        case (hdr_idx_r)
          3'd0:    tx_data = SOF_BYTE;
          3'd1:    tx_data = id_r[15:8];
          3'd2:    tx_data = id_r[7:0];
          3'd3:    tx_data = status_r;
          3'd4:    tx_data = 8'(len_r);
          default: tx_data = '0;
        endcase
      end
      ST_PAYLOAD: begin
        tx_valid = 1'b1;
        tx_data  = pay_r[pay_idx_r];
      end
      ST_CKSUM: begin
        tx_valid = 1'b1;
        tx_data  = cksum_r;
      end
      default: begin
        tx_data  = '0;
        tx_valid = 1'b0;
      end
    endcase
  end

  assign busy  = (state_r == ST_HDR) || (state_r == ST_PAYLOAD) || (state_r == ST_CKSUM);
  assign done  = (state_r == ST_FIN) || rej_r;
  assign error = rej_r;

endmodule

// File: tb/tb_host_uart_rsp_framer.sv
// Self-checking bench for host_uart_rsp_framer: fixed vectors, corner sequences and random requests vs. a frame model.
module tb_host_uart_rsp_framer;

  localparam int MAXP = 32;
  localparam int LW   = 6;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic [15:0] id;
    bit          st;
    logic [31:0] pl;
    int          plen;
    bit          legal;
    int          nb;
    logic [79:0] bytes;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [15:0]       cmd_select;
  logic              suc_or_fail_status;
  logic [8*MAXP-1:0] payload;
  logic [LW-1:0]     payload_len;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;
  logic              error;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  host_uart_rsp_framer #(
    .MAX_PAYLOAD_BYTES (MAXP),
    .LEN_W             (LW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .cmd_select         (cmd_select),
    .suc_or_fail_status (suc_or_fail_status),
    .payload            (payload),
    .payload_len        (payload_len),
    .tx_data            (tx_data),
    .tx_valid           (tx_valid),
    .tx_ready           (tx_ready),
    .busy               (busy),
    .done               (done),
    .error              (error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame model built directly from the per-ID rules.
  function automatic void model_frame(input logic [15:0] id, input bit st, input logic [8*MAXP-1:0] pl,
                                      input int plen, output byte_q_t q, output bit legal);
    int n;
    logic [7:0] sb;
    logic [7:0] ck;
    q = {};
    legal = 1'b1;
    sb = st ? 8'h01 : 8'h00;
    n = 0;
    case (id)
      16'h0001: n = 0;
      16'h0002: n = st ? 4 : 0;
      16'h0004: sb = 8'h00;
      16'h0008: if (plen > MAXP) legal = 1'b0; else n = plen;
      default:  legal = 1'b0;
    endcase
    if (!legal) return;
    q.push_back(8'hA5);
    q.push_back(id[15:8]);
    q.push_back(id[7:0]);
    q.push_back(sb);
    q.push_back(8'(n));
    for (int i = 0; i < n; i++) q.push_back(pl[8*i +: 8]);
    ck = 8'h00;
    for (int i = 1; i < q.size(); i++) ck = ck ^ q[i];
    q.push_back(ck);
  endfunction

  function automatic logic [8*MAXP-1:0] rand_payload();
    logic [8*MAXP-1:0] p;
    for (int i = 0; i < MAXP / 4; i++) p[32*i +: 32] = $urandom;
    return p;
  endfunction

  // Called at a negedge; returns at the negedge after done (or after a timeout).
  // rmode: 0 = ready high, 1 = ready toggles, 2 = random ready.
  task automatic run_req(input string name, input logic [15:0] id, input bit st, input logic [8*MAXP-1:0] pl,
                         input int plen, input int rmode, input bit restart,
                         input byte_q_t exp_q, input bit exp_legal);
    byte_q_t got_q;
    int stalls = 0;
    int done_c = -1;
    logic err_v = 1'b0;
    logic busy_at_done = 1'b0;
    bit busy_seen = 1'b0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    bit rdy;
    got_q = {};
    cmd_select = id;
    suc_or_fail_status = st;
    payload = pl;
    payload_len = LW'(plen);
    start = 1'b1;
    tx_ready = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        cmd_select = 16'($urandom);
        suc_or_fail_status = ~st;
        payload = rand_payload();
        payload_len = LW'($urandom);
        chk({name, "_first_valid"}, 32'(tx_valid), 32'(exp_legal));
      end
      if (restart && c == 3) begin
        start = 1'b1;
        cmd_select = 16'h0001;
      end else if (restart && c == 4) begin
        start = 1'b0;
      end
      if (busy) busy_seen = 1'b1;
      if (done) begin
        done_c = c;
        err_v = error;
        busy_at_done = busy;
        break;
      end
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = c[0];
        default: rdy = ($urandom % 4) != 0;
      endcase
      tx_ready = rdy;
      if (tx_valid) begin
        if (prev_stall) chk({name, "_stall_stable"}, 32'(tx_data), 32'(prev_data));
        if (rdy) got_q.push_back(tx_data);
        else stalls++;
        prev_stall = !rdy;
        prev_data = tx_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
    tx_ready = 1'b1;
    if (done_c < 0) begin
      chk({name, "_timeout"}, 32'd1, 32'd0);
      return;
    end
    chk({name, "_error"}, 32'(err_v), 32'(!exp_legal));
    chk({name, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    chk({name, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    if (exp_legal) chk({name, "_done_cycle"}, 32'(done_c), 32'(exp_q.size() + 1 + stalls));
    else begin
      chk({name, "_done_cycle"}, 32'(done_c), 32'd1);
      chk({name, "_busy_seen"}, 32'(busy_seen), 32'd0);
    end
    @(negedge clk);
    chk({name, "_done_pulse"}, {29'd0, done, error, busy}, 32'd0);
  endtask

  vec_t vecs [10];

  function automatic vec_t mkv(input logic [15:0] id, input bit st, input logic [31:0] pl, input int plen,
                               input bit legal, input int nb, input logic [79:0] bytes);
    vec_t v;
    v.id = id; v.st = st; v.pl = pl; v.plen = plen;
    v.legal = legal; v.nb = nb; v.bytes = bytes;
    return v;
  endfunction

  initial begin
    byte_q_t q;
    bit lg;
    logic [8*MAXP-1:0] pl;
    logic [15:0] id;
    bit st;
    int plen;
    int dc;
    bit seen;
    int nbytes;

    vecs[0] = mkv(16'h0001, 1, 32'h0,        0,  1, 6,  80'hA5_00_01_01_00_00_00000000);
    vecs[1] = mkv(16'h0002, 1, 32'h04030201, 0,  1, 10, 80'hA5_00_02_01_04_01_02_03_04_03);
    vecs[2] = mkv(16'h0002, 0, 32'h04030201, 0,  1, 6,  80'hA5_00_02_00_00_02_00000000);
    vecs[3] = mkv(16'h0004, 1, 32'h0,        0,  1, 6,  80'hA5_00_04_00_00_04_00000000);
    vecs[4] = mkv(16'h0003, 1, 32'h0,        0,  0, 0,  80'h0);
    vecs[5] = mkv(16'h0008, 1, 32'h0,        33, 0, 0,  80'h0);
    vecs[6] = mkv(16'h0008, 1, 32'h0,        0,  1, 6,  80'hA5_00_08_01_00_09_00000000);
    vecs[7] = mkv(16'h0008, 0, 32'h00CCBBAA, 3,  1, 9,  80'hA5_00_08_00_03_AA_BB_CC_D6_00);
    vecs[8] = mkv(16'h0100, 1, 32'h0,        0,  0, 0,  80'h0);
    vecs[9] = mkv(16'h0001, 0, 32'h0,        0,  1, 6,  80'hA5_00_01_00_00_01_00000000);

    reset = 1'b1;
    start = 1'b0;
    cmd_select = '0;
    suc_or_fail_status = 1'b0;
    payload = '0;
    payload_len = '0;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_tx_data", 32'(tx_data), 32'd0);
    chk("reset_flags", {28'd0, tx_valid, busy, done, error}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[k]) begin
      logic [79:0] b;
      q = {};
      b = vecs[k].bytes;
      for (int i = 0; i < vecs[k].nb; i++) q.push_back(b[79-8*i -: 8]);
      run_req($sformatf("vec%0d", k), vecs[k].id, vecs[k].st, {224'd0, vecs[k].pl},
              vecs[k].plen, 0, 1'b0, q, vecs[k].legal);
    end

    pl = rand_payload();
    model_frame(16'h0008, 1'b1, pl, 32, q, lg);
    run_req("gen32_toggle", 16'h0008, 1'b1, pl, 32, 1, 1'b1, q, lg);

    // Reset during payload byte 2: frame byte 7, on the bus in cycle 8 with ready high.
    pl = rand_payload();
    cmd_select = 16'h0008; suc_or_fail_status = 1'b1; payload = pl; payload_len = LW'(8);
    start = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("rst_pre_byte", 32'(tx_data), 32'(pl[23:16]));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_flags", {28'd0, tx_valid, busy, done, error}, 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || tx_valid) seen = 1'b1;
    end
    chk("rst_no_done", 32'(seen), 32'd0);
    model_frame(16'h0001, 1'b1, '0, 0, q, lg);
    run_req("post_rst", 16'h0001, 1'b1, '0, 0, 0, 1'b0, q, lg);

    // Back-to-back: start in the done cycle of the previous frame.
    cmd_select = 16'h0001; suc_or_fail_status = 1'b1;
    start = 1'b1;
    dc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin dc = c; break; end
    end
    chk("b2b_first_done", 32'(dc), 32'd7);
    cmd_select = 16'h0002; suc_or_fail_status = 1'b1; payload = {224'd0, 32'h04030201};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_sof", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hA5});
    nbytes = 0;
    dc = -1;
    for (int c = 1; c <= 20; c++) begin
      if (tx_valid) nbytes++;
      if (done) begin dc = c; break; end
      @(negedge clk);
    end
    chk("b2b_second_nbytes", 32'(nbytes), 32'd10);
    chk("b2b_second_done", 32'(dc), 32'd11);
    @(negedge clk);

    for (int r = 0; r < 25; r++) begin
      case ($urandom % 6)
        0:       id = 16'h0001;
        1:       id = 16'h0002;
        2:       id = 16'h0004;
        3, 4:    id = 16'h0008;
        default: id = 16'($urandom);
      endcase
      st = 1'($urandom);
      pl = rand_payload();
      plen = int'($urandom_range(0, 36));
      model_frame(id, st, pl, plen, q, lg);
      run_req($sformatf("rnd%0d", r), id, st, pl, plen, 2, lg && ($urandom % 3 == 0), q, lg);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/host_uart_rsp_framer.md
# host_uart_rsp_framer

Parametrised host-UART response framer. It turns a response request (response ID, success/fail status, optional payload) into a complete byte-serial frame: SOF, ID, status, length, payload, XOR checksum. Bytes go out on a valid/ready stream toward the UART transmitter. It succeeds the fixed-width response encoder: payload length is variable up to a parameter, output is backpressure-aware, and unknown responses are rejected without emitting bytes.

## Interface
- `MAX_PAYLOAD_BYTES`, default 32: largest payload the framer will send; must be ≤ 255.
- `LEN_W`, default `$clog2(MAX_PAYLOAD_BYTES+1)`: width of `payload_len`.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request strobe; ignored while `busy`.
- `cmd_select` in 16: response ID.
- `suc_or_fail_status` in 1: 1 = success, 0 = fail.
- `payload` in 8*MAX_PAYLOAD_BYTES: payload bytes; byte k is `payload[8k+7:8k]`, and byte 0 is sent first.
- `payload_len` in LEN_W: byte count; used only for GENERIC_RSP.
- `tx_data` out 8: current frame byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: sink accepts the byte when `tx_valid && tx_ready`.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse at the end of each request.
- `error` out 1: one-cycle pulse, coincident with `done`, marking a rejected request.

## Operation
- **Capture.** On `start` in IDLE, latch `cmd_select`, status, `payload` and the resolved length. Inputs may change afterwards without effect.
- **Frame layout.**
  - SOF `0xA5`.
  - ID[15:8], then ID[7:0].
  - Status byte: `0x01` success, `0x00` fail.
  - LEN.
  - LEN payload bytes.
  - CKSUM: XOR of every byte after SOF, up to and including the last payload byte.
- **Per-ID rules.**
  - ENCRYPT_ENABLE_RSP `0x0001`: LEN = 0.
  - READ_YAW_RSP `0x0002`: LEN = 4 on success; LEN = 0 on fail.
  - INVALID_COMMAND_RSP `0x0004`: status byte forced to `0x00`; LEN = 0.
  - GENERIC_RSP `0x0008`: LEN = `payload_len`. If `payload_len > MAX_PAYLOAD_BYTES`, the request is rejected.
  - Any other ID is rejected.
- **Rejected request.** No bytes are emitted, `busy` never rises, and `done` and `error` pulse together in the next cycle.
- **State machine.**
  - IDLE → HDR on a legal `start`.
  - HDR steps a byte index 0..4 (SOF..LEN); after the LEN handshake it goes to PAYLOAD if LEN > 0, otherwise to CKSUM.
  - PAYLOAD steps the index up to LEN-1, then goes to CKSUM.
  - CKSUM → FIN after its handshake.
  - FIN pulses `done` and returns to IDLE.
  - A state advances only on a handshake.
- **Checksum.** An 8-bit accumulator is cleared at start and XOR-updated on each handshake of a byte from ID[15:8] through the last payload byte.
- **Busy start.** A `start` while `busy` is dropped, with no error.
- **Stream rule.** Once `tx_valid` is high, `tx_valid` and `tx_data` stay stable until the handshake; no bubbles are inserted.

## Timing
- **Reset.** `tx_data`, `tx_valid`, `busy`, `done`, `error` and the checksum are all 0, and state is IDLE, in the cycle after reset is sampled. Reset mid-frame aborts the frame with no `done`.
- **Latency.** With `start` sampled at edge N, `tx_valid` is high with SOF from cycle N+1.
- **Throughput.** With `tx_ready` held high: one byte per cycle, frame of 6+LEN bytes, and `done` high in cycle N+7+LEN.
- **Backpressure.** Each cycle of low `tx_ready` adds exactly one cycle.
- **Back-to-back requests.** `busy` falls in the `done` cycle, so `start` is accepted in that same cycle, giving zero gap between frames.
- **Rejected request timing.** `done` and `error` are high in cycle N+1 only.

## Structure
- **Package `host_uart_pkg`:**
  - response ID localparams (ENCRYPT_ENABLE_RSP, READ_YAW_RSP, INVALID_COMMAND_RSP, GENERIC_RSP);
  - `SOF_BYTE = 8'hA5`;
  - status codes;
  - framer state enum.
- **Sub-module `host_uart_rsp_rules`** (combinational): maps `cmd_select`, status and `payload_len` to resolved LEN, status byte and legal flag.
- **Top level:** FSM, byte mux, payload index counter and checksum.

## Test plan
1. ENCRYPT_ENABLE_RSP, success, `tx_ready` held high → bytes A5 00 01 01 00 00; `done` in cycle N+7; `error` = 0.
2. READ_YAW_RSP, success, `payload = 32'h04030201` → bytes A5 00 02 01 04 01 02 03 04 03; `done` in cycle N+11.
3. READ_YAW_RSP, fail → bytes A5 00 02 00 00 02. INVALID_COMMAND_RSP with status = 1 → bytes A5 00 04 00 00 04.
4. `cmd_select = 0x0003`; separately, GENERIC_RSP with `payload_len = 33` → `done` and `error` in cycle N+1; `tx_valid` never high.
5. GENERIC_RSP, `payload_len = 32`, `tx_ready` toggling 1/0 → 38 bytes, correct checksum, `tx_data` stable while stalled; a second `start` mid-frame is ignored.
6. `reset` asserted during payload byte 2 → all outputs 0 the next cycle, no `done`; a following ENCRYPT_ENABLE_RSP frame is correct.
